wash_program_controller: RTL and testbench

//  Next-generation washing-machine sequencer: FILL, then N x (WASH, RINSE), then SPIN.
//  N is selected per program at coin time. Adds pause on every timed phase, abort with a

---
 rtl/wash_program_controller_pkg.sv | 15 +
 rtl/wash_program_controller_if.sv | 18 +
 rtl/wash_program_controller_phase_timer.sv | 19 +
 rtl/wash_program_controller.sv | 129 ++++++++++++
 tb/tb_wash_program_controller.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/wash_program_controller_pkg.sv
// wash_program_controller_pkg: phase encodings and tick-count helper shared by the controller and its benches
package wash_program_controller_pkg;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WASH  = 3'd2,
    ST_RINSE = 3'd3,
    ST_SPIN  = 3'd4,
    ST_DRAIN = 3'd5
  } state_e;
  function automatic longint unsigned at_least_one(input longint unsigned v);
    return (v == 0) ? 64'd1 : v;
  endfunction
endpackage

// File: rtl/wash_program_controller_if.sv
// wash_program_controller_if: control inputs and live status of the wash sequencer
interface wash_program_controller_if #(parameter int CNT_W = 32, parameter int CYC_W = 3);
  logic             tick;
  logic             coin;
  logic [CYC_W-1:0] cycles_sel;
  logic             pause;
  logic             abort;
  logic [2:0]       state;
  logic [CNT_W-1:0] remaining;
  logic [CYC_W-1:0] cycle_idx;
  logic             busy;
  logic             wash_done;
  logic             aborted;
  modport master (output tick, coin, cycles_sel, pause, abort,
                  input state, remaining, cycle_idx, busy, wash_done, aborted);
  modport slave  (input tick, coin, cycles_sel, pause, abort,
                  output state, remaining, cycle_idx, busy, wash_done, aborted);
endinterface

// File: rtl/wash_program_controller_phase_timer.sv
// wash_program_controller_phase_timer: loadable down-counter that flags the last enabled tick of a phase
module wash_program_controller_phase_timer #(parameter int CNT_W = 32) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_expire
);
  logic [CNT_W-1:0] r_count;
  always_ff @(posedge clk) begin
    if (!reset) r_count <= '0;
    else if (i_load) r_count <= i_load_val;
    else if (i_en && r_count > CNT_W'(1)) r_count <= r_count - CNT_W'(1);
  end
  assign o_count  = r_count;
  assign o_expire = i_en && (r_count == CNT_W'(1));
endmodule

// File: rtl/wash_program_controller.sv
// wash_program_controller: FILL, N x (WASH, RINSE), SPIN sequencer with pause, abort-to-drain and live status
module wash_program_controller
  import wash_program_controller_pkg::*;
#(
  parameter int          CNT_W       = 32,
  parameter int unsigned FILL_TICKS  = 120000000,
  parameter int unsigned WASH_TICKS  = 300000000,
  parameter int unsigned RINSE_TICKS = 120000000,
  parameter int unsigned SPIN_TICKS  = 60000000,
  parameter int unsigned DRAIN_TICKS = 30000000,
  parameter int          MAX_CYCLES  = 4,
  parameter int          CYC_W       = 3
) (
  input logic clk,
  input logic reset,
  wash_program_controller_if.slave bus
);
  localparam logic [CNT_W-1:0] L_FILL  = CNT_W'(at_least_one(64'(FILL_TICKS)));
  localparam logic [CNT_W-1:0] L_WASH  = CNT_W'(at_least_one(64'(WASH_TICKS)));
  localparam logic [CNT_W-1:0] L_RINSE = CNT_W'(at_least_one(64'(RINSE_TICKS)));
  localparam logic [CNT_W-1:0] L_SPIN  = CNT_W'(at_least_one(64'(SPIN_TICKS)));
  localparam logic [CNT_W-1:0] L_DRAIN = CNT_W'(at_least_one(64'(DRAIN_TICKS)));
  localparam logic [CYC_W-1:0] L_MAXC  = CYC_W'(MAX_CYCLES);
  state_e           r_state;
  logic [CYC_W-1:0] r_cyc;
  logic [CYC_W-1:0] r_n;
  logic             r_busy;
  logic             r_wd;
  logic             r_ab;
  logic             w_timed;
  logic             w_more;
  logic             w_en;
  logic             w_expire;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic [CNT_W-1:0] w_count;
  logic [CYC_W-1:0] w_n;
  assign w_timed = (r_state == ST_FILL) || (r_state == ST_WASH) ||
                   (r_state == ST_RINSE) || (r_state == ST_SPIN);
  assign w_more  = r_cyc < r_n;
  assign w_en    = bus.tick && !(bus.pause && w_timed);
  assign w_n     = (bus.cycles_sel == '0) ? CYC_W'(1) :
                   (bus.cycles_sel > L_MAXC) ? L_MAXC : bus.cycles_sel;
  // Abort outranks expiry, so the drain count wins any same-edge load
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    if (r_state == ST_IDLE) begin
      w_load     = bus.coin;
      w_load_val = L_FILL;
    end else if (w_timed) begin
      w_load     = bus.abort || w_expire;
      w_load_val = bus.abort ? L_DRAIN :
                   (r_state == ST_FILL) ? L_WASH :
                   (r_state == ST_WASH) ? L_RINSE :
                   (r_state == ST_RINSE) ? (w_more ? L_WASH : L_SPIN) : '0;
    end else begin
      w_load = (r_state != ST_DRAIN) || w_expire;
    end
  end
  wash_program_controller_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (w_en),
    .o_count    (w_count),
    .o_expire   (w_expire)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cyc   <= '0;
      r_n     <= '0;
      r_busy  <= 1'b0;
      r_wd    <= 1'b0;
      r_ab    <= 1'b0;
    end else begin
      r_wd <= 1'b0;
      r_ab <= 1'b0;
      case (r_state)
        ST_IDLE: if (bus.coin) begin
          r_state <= ST_FILL;
          r_n     <= w_n;
          r_busy  <= 1'b1;
        end
        ST_FILL, ST_WASH, ST_RINSE, ST_SPIN: begin
          if (bus.abort) r_state <= ST_DRAIN;
          else if (w_expire) begin
            case (r_state)
              ST_FILL: begin
                r_state <= ST_WASH;
                r_cyc   <= CYC_W'(1);
              end
              ST_WASH: r_state <= ST_RINSE;
              ST_RINSE: begin
                r_state <= w_more ? ST_WASH : ST_SPIN;
                r_cyc   <= w_more ? r_cyc + CYC_W'(1) : r_cyc;
              end
              default: begin
                r_state <= ST_IDLE;
                r_cyc   <= '0;
                r_busy  <= 1'b0;
                r_wd    <= 1'b1;
              end
            endcase
          end
        end
        ST_DRAIN: if (w_expire) begin
          r_state <= ST_IDLE;
          r_cyc   <= '0;
          r_busy  <= 1'b0;
          r_ab    <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cyc   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
  assign bus.state     = r_state;
  assign bus.remaining = w_count;
  assign bus.cycle_idx = r_cyc;
  assign bus.busy      = r_busy;
  assign bus.wash_done = r_wd;
  assign bus.aborted   = r_ab;
endmodule

// File: tb/tb_wash_program_controller.sv
// tb_wash_program_controller: directed scenarios checked cycle by cycle against a queued reference model
module tb_wash_program_controller;
  import wash_program_controller_pkg::*;
  localparam int F = 3, W = 5, R = 4, S = 2, D = 3, MAXC = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  wash_program_controller_if #(.CNT_W(32), .CYC_W(3)) bus ();
  wash_program_controller #(
    .CNT_W(32), .FILL_TICKS(F), .WASH_TICKS(W), .RINSE_TICKS(R),
    .SPIN_TICKS(S), .DRAIN_TICKS(D), .MAX_CYCLES(MAXC), .CYC_W(3)
  ) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int since = 0, wd_at = -1, wd_cnt = 0, ab_at = -1, ab_cnt = 0, max_cyc = 0;
  int m_st = 0, m_rem = 0, m_cyc = 0, m_n = 0, m_wd = 0, m_ab = 0;
  logic [40:0] exp_q[$];
  function automatic logic [40:0] pack(int st, int rem, int cyc, bit b, bit wd, bit ab);
    return {3'(st), 32'(rem), 3'(cyc), b, wd, ab};
  endfunction
  task automatic chk(string tag, longint got, longint exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic model();
    m_wd = 0;
    m_ab = 0;
    if (!reset) begin
      m_st = 0; m_rem = 0; m_cyc = 0; m_n = 0;
    end else if (m_st == 0) begin
      if (bus.coin) begin
        m_st = 1; m_rem = F;
        m_n = (bus.cycles_sel == 0) ? 1 : (int'(bus.cycles_sel) > MAXC) ? MAXC : int'(bus.cycles_sel);
      end
    end else if (m_st == 5) begin
      if (bus.tick) begin
        if (m_rem > 1) m_rem--;
        else begin m_st = 0; m_rem = 0; m_cyc = 0; m_ab = 1; end
      end
    end else if (bus.abort) begin
      m_st = 5; m_rem = D;
    end else if (bus.tick && !bus.pause) begin
      if (m_rem > 1) m_rem--;
      else if (m_st == 1) begin m_st = 2; m_rem = W; m_cyc = 1; end
      else if (m_st == 2) begin m_st = 3; m_rem = R; end
      else if (m_st == 3 && m_cyc < m_n) begin m_st = 2; m_rem = W; m_cyc++; end
      else if (m_st == 3) begin m_st = 4; m_rem = S; end
      else begin m_st = 0; m_rem = 0; m_cyc = 0; m_wd = 1; end
    end
  endtask
  task automatic step();
    logic [40:0] got, exp;
    model();
    exp_q.push_back(pack(m_st, m_rem, m_cyc, m_st != 0, m_wd[0], m_ab[0]));
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    got = {bus.state, bus.remaining, bus.cycle_idx, bus.busy, bus.wash_done, bus.aborted};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL cycle t=%0t got st=%0d rem=%0d cyc=%0d busy=%b wd=%b ab=%b exp st=%0d rem=%0d cyc=%0d busy=%b wd=%b ab=%b",
             $time, got[40:38], got[37:6], got[5:3], got[2], got[1], got[0],
             exp[40:38], exp[37:6], exp[5:3], exp[2], exp[1], exp[0]);
    end
    since++;
    if (bus.wash_done) begin wd_at = since; wd_cnt++; end
    if (bus.aborted) begin ab_at = since; ab_cnt++; end
    if (int'(bus.cycle_idx) > max_cyc) max_cyc = int'(bus.cycle_idx);
  endtask
  task automatic start(int sel);
    bus.cycles_sel = 3'(sel);
    bus.coin = 1'b1;
    step();
    bus.coin = 1'b0;
    since = 0; wd_at = -1; wd_cnt = 0; ab_at = -1; ab_cnt = 0; max_cyc = 0;
  endtask
  initial begin
    bus.tick = 1'b1; bus.coin = 1'b0; bus.cycles_sel = '0; bus.pause = 1'b0; bus.abort = 1'b0;
    repeat (2) step();
    chk("reset_outputs", {bus.state, bus.remaining, bus.cycle_idx, bus.busy, bus.wash_done, bus.aborted}, 0);
    reset = 1'b1;
    step();
    start(1);
    repeat (14) step();
    chk("basic_done_at", wd_at, 14);
    chk("basic_done_cnt", wd_cnt, 1);
    start(3);
    repeat (32) step();
    chk("multi_done_at", wd_at, 32);
    chk("multi_max_cyc", max_cyc, 3);
    start(0);
    repeat (14) step();
    chk("clamp0_done_at", wd_at, 14);
    start(7);
    repeat (5) step();
    bus.coin = 1'b1; step();
    bus.coin = 1'b0; step();
    bus.coin = 1'b1; step();
    bus.coin = 1'b0;
    repeat (36) step();
    chk("clamp7_done_at", wd_at, 41);
    chk("clamp7_done_cnt", wd_cnt, 1);
    chk("clamp7_max_cyc", max_cyc, 4);
    start(1);
    repeat (5) step();
    bus.pause = 1'b1;
    repeat (10) step();
    chk("pause_rem_frozen", bus.remaining, 3);
    bus.pause = 1'b0;
    repeat (9) step();
    chk("pause_done_at", wd_at, 24);
    start(1);
    repeat (2) step();
    bus.abort = 1'b1; step();
    bus.abort = 1'b0; bus.pause = 1'b1;
    repeat (3) step();
    bus.pause = 1'b0;
    step();
    chk("drain_pause_ab_at", ab_at, 6);
    chk("drain_pause_no_done", wd_cnt, 0);
    start(2);
    repeat (9) step();
    bus.abort = 1'b1; step();
    bus.abort = 1'b0;
    chk("abort_rinse_state", bus.state, ST_DRAIN);
    chk("abort_rinse_rem", bus.remaining, D);
    repeat (3) step();
    chk("abort_rinse_ab_at", ab_at, 13);
    chk("abort_rinse_no_done", wd_cnt, 0);
    start(1);
    repeat (13) step();
    bus.abort = 1'b1; step();
    bus.abort = 1'b0;
    chk("abort_spin_state", bus.state, ST_DRAIN);
    repeat (3) step();
    chk("abort_spin_ab_cnt", ab_cnt, 1);
    chk("abort_spin_no_done", wd_cnt, 0);
    start(1);
    repeat (13) step();
    reset = 1'b0; step();
    chk("midreset_outputs", {bus.state, bus.remaining, bus.cycle_idx, bus.busy, bus.wash_done, bus.aborted}, 0);
    reset = 1'b1;
    repeat (3) step();
    chk("midreset_no_done", wd_cnt, 0);
    start(1);
    for (int k = 1; k <= 56; k++) begin
      bus.tick = (k % 4 == 0);
      step();
    end
    bus.tick = 1'b1;
    chk("slow_tick_done_at", wd_at, 56);
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
